// File: rtl/filter_mac_accum.sv
// Accumulate-and-sequence stage for the fixed-point filter datapath.
// Drives the accumulator mux select, sums TAPS products onto a preload, then saturates and rescales the result.
module filter_mac_accum #(
    parameter int N    = 25,
    parameter int TAPS = 5,
    parameter int FRAC = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic signed [2*N-1:0] mux_y,
    input  logic signed [2*N-1:0] product,
    output logic [1:0]            sel,
    output logic [3:0]            tap_idx,
    output logic signed [2*N-1:0] acc,
    output logic signed [N-1:0]   y_out,
    output logic                  busy,
    output logic                  done
);

    localparam int W = 2 * N;
    localparam logic [3:0] LAST_TAP = 4'(TAPS - 1);
    localparam logic signed [W-1:0] ACC_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] ACC_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [N-1:0] Y_MAX   = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] Y_MIN   = {1'b1, {(N-1){1'b0}}};

    localparam logic [1:0] SEL_UK   = 2'b00;
    localparam logic [1:0] SEL_ACUM = 2'b01;
    localparam logic [1:0] SEL_ZERO = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ACCUM,
        SAT,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic signed [W-1:0] acc_q, acc_d;
    logic [3:0]          tap_q, tap_d;
    logic signed [N-1:0] y_q, y_d;

    logic signed [W:0]   sum;
    logic signed [W-1:0] acc_sat;
    logic signed [W-1:0] shifted;
    logic signed [N-1:0] y_sat;

    // One guard bit on the add: disagreement between the top two bits means overflow.
    always_comb begin
        sum = {mux_y[W-1], mux_y} + {product[W-1], product};
        if (sum[W] != sum[W-1]) begin
            acc_sat = sum[W] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_sat = sum[W-1:0];
        end
    end

    // The shifted value fits in N bits only when all bits above the N-bit sign match it.
    always_comb begin
        shifted = acc_q >>> FRAC;
        if (shifted[W-1:N-1] == {(W-N+1){shifted[W-1]}}) begin
            y_sat = shifted[N-1:0];
        end else begin
            y_sat = shifted[W-1] ? Y_MIN : Y_MAX;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        tap_d   = tap_q;
        y_d     = y_q;
        sel     = SEL_ZERO;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                sel     = SEL_UK;
                busy    = 1'b1;
                acc_d   = mux_y;
                tap_d   = 4'd0;
                state_d = ACCUM;
            end
            ACCUM: begin
                sel   = SEL_ACUM;
                busy  = 1'b1;
                acc_d = acc_sat;
                tap_d = tap_q + 4'd1;
                if (tap_q == LAST_TAP) begin
                    state_d = SAT;
                end
            end
            SAT: begin
                sel     = SEL_ACUM;
                busy    = 1'b1;
                y_d     = y_sat;
                tap_d   = 4'd0;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = start ? LOAD : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            tap_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            tap_q   <= tap_d;
            y_q     <= y_d;
        end
    end

    assign acc     = acc_q;
    assign tap_idx = tap_q;
    assign y_out   = y_q;

endmodule

// File: tb/tb_filter_mac_accum.sv
// Randomized bench for filter_mac_accum: a cycle-count reference model plus a mux/multiplier
// environment, with literal expectations for the nominal and saturating cases.
module tb_filter_mac_accum;

    localparam int N    = 25;
    localparam int TAPS = 5;
    localparam int FRAC = 10;
    localparam int W    = 2 * N;
    localparam int LAT  = TAPS + 3;

    localparam logic signed [W:0] MAX2 = {2'b00, {(W-1){1'b1}}};
    localparam logic signed [W:0] MIN2 = {2'b11, {(W-1){1'b0}}};
    localparam longint MAXN = (64'sd1 <<< (N - 1)) - 64'sd1;
    localparam longint MINN = -(64'sd1 <<< (N - 1));

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                start = 1'b0;
    logic signed [W-1:0] muxY;
    logic signed [W-1:0] product;
    logic [1:0]          sel;
    logic [3:0]          tapIdx;
    logic signed [W-1:0] acc;
    logic signed [N-1:0] yOut;
    logic                busy;
    logic                done;

    logic signed [W-1:0] uk = '0;
    logic signed [W-1:0] prods [TAPS];

    int checks = 0;
    int failures = 0;

    filter_mac_accum #(.N(N), .TAPS(TAPS), .FRAC(FRAC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mux_y(muxY), .product(product),
        .sel(sel), .tap_idx(tapIdx), .acc(acc), .y_out(yOut), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Environment: the accumulator input mux and a multiplier fed from a per-tap table.
    assign muxY    = (sel == 2'b00) ? uk : (sel == 2'b01) ? acc : '0;
    assign product = (tapIdx < 4'(TAPS)) ? prods[tapIdx] : '0;

    function automatic logic signed [W-1:0] sat2N(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        logic signed [W:0] s;
        s = a + b;
        if (s > MAX2) return MAX2[W-1:0];
        if (s < MIN2) return MIN2[W-1:0];
        return s[W-1:0];
    endfunction

    function automatic logic signed [N-1:0] satN(input logic signed [W-1:0] a);
        longint v;
        v = longint'(a) >>> FRAC;
        if (v > MAXN) v = MAXN;
        if (v < MINN) v = MINN;
        return N'(v);
    endfunction

    function automatic logic signed [W-1:0] pow2(input int e);
        return W'(64'sd1 <<< e);
    endfunction

    function automatic logic signed [W-1:0] randVal();
        logic [63:0] r;
        logic signed [21:0] s;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 2))
            0: return r[W-1:0];
            1: begin
                s = r[21:0];
                return W'(s);
            end
            default: return r[63] ? MIN2[W-1:0] : MAX2[W-1:0];
        endcase
    endfunction

    // Reference model: k counts cycles since an accepted start (0 = idle, LAT = done cycle).
    int                  k = 0;
    logic signed [W-1:0] expAcc = '0;
    logic signed [N-1:0] expY = '0;
    logic signed [W-1:0] runUk = '0;
    logic signed [W-1:0] runP [TAPS];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k      <= 0;
            expAcc <= '0;
            expY   <= '0;
        end else if (k == 0 || k == LAT) begin
            if (start) begin
                k     <= 1;
                runUk <= uk;
                runP  <= prods;
            end else begin
                k <= 0;
            end
        end else begin
            k <= k + 1;
            if (k == 1) expAcc <= runUk;
            else if (k <= TAPS + 1) expAcc <= sat2N(expAcc, runP[k-2]);
            else expY <= satN(expAcc);
        end
    end

    task automatic checkOutput(input string name, input logic signed [63:0] actual, input logic signed [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("sel", 64'(sel), (k == 1) ? 64'sd0 : (k >= 2 && k <= TAPS + 2) ? 64'sd1 : 64'sd2);
            checkOutput("busy", 64'(busy), (k >= 1 && k <= TAPS + 2) ? 64'sd1 : 64'sd0);
            checkOutput("done", 64'(done), (k == LAT) ? 64'sd1 : 64'sd0);
            checkOutput("acc", acc, expAcc);
            checkOutput("yOut", yOut, expY);
            if (k != TAPS + 2)
                checkOutput("tapIdx", 64'(tapIdx), (k >= 2 && k <= TAPS + 1) ? 64'(k - 2) : 64'sd0);
        end
    end

    task automatic setAll(input logic signed [W-1:0] u, input logic signed [W-1:0] p);
        uk = u;
        foreach (prods[i]) prods[i] = p;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_sel"}, 64'(sel), 64'sd2);
        checkOutput({tag, "_busy"}, 64'(busy), 64'sd0);
        checkOutput({tag, "_done"}, 64'(done), 64'sd0);
        checkOutput({tag, "_acc"}, acc, 64'sd0);
        checkOutput({tag, "_y"}, yOut, 64'sd0);
        checkOutput({tag, "_tap"}, 64'(tapIdx), 64'sd0);
    endtask

    // One sample: start for one cycle, optionally re-pulse start at cycle pulseAt, return the done cycle.
    task automatic applyStimulus(input int pulseAt, output int doneAt);
        doneAt = -1;
        @(negedge clk);
        start = 1'b1;
        for (int i = 1; i <= LAT + 10; i++) begin
            @(negedge clk);
            start = (i == pulseAt);
            if (done) begin
                doneAt = i;
                break;
            end
        end
        start = 1'b0;
        checkOutput("doneLatency", 64'(doneAt), 64'(LAT));
    endtask

    task automatic waitDone(input string name, output int gap);
        gap = -1;
        for (int i = 1; i <= LAT + 10; i++) begin
            @(negedge clk);
            if (done) begin
                gap = i;
                break;
            end
        end
        checkOutput(name, 64'(gap), 64'(LAT));
    endtask

    initial begin
        int d;
        int extra;
        foreach (prods[i]) prods[i] = '0;

        #3 rst_n = 1'b0;
        #1 checkResetValues("asyncReset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("idleSel", 64'(sel), 64'sd2);

        setAll(pow2(20), pow2(20));
        applyStimulus(0, d);
        checkOutput("nominalAcc", acc, 64'sd6291456);
        checkOutput("nominalY", yOut, 64'sd6144);

        setAll(pow2(48), pow2(48));
        applyStimulus(0, d);
        checkOutput("posSatAcc", acc, 64'sd562949953421311);
        checkOutput("posSatY", yOut, 64'sd16777215);

        setAll(-pow2(48), -pow2(48));
        applyStimulus(0, d);
        checkOutput("negSatAcc", acc, -64'sd562949953421312);
        checkOutput("negSatY", yOut, -64'sd16777216);

        setAll(pow2(20), pow2(20));
        applyStimulus(3, d);
        checkOutput("ignoredStartY", yOut, 64'sd6144);
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) extra++;
        end
        checkOutput("noSecondRun", 64'(extra), 64'sd0);

        // Back-to-back: the second sample preloads zero, so a stale sum would show as 11264.
        setAll(pow2(20), pow2(20));
        @(negedge clk);
        start = 1'b1;
        waitDone("b2bFirstDone", d);
        checkOutput("b2bFirstY", yOut, 64'sd6144);
        uk = '0;
        waitDone("b2bGap", d);
        checkOutput("b2bSecondY", yOut, 64'sd5120);
        start = 1'b0;
        repeat (3) @(negedge clk);

        setAll(pow2(20), pow2(20));
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d = 0;
        for (int i = 0; i < 2 * LAT; i++) begin
            if (busy && sel == 2'b01 && tapIdx == 4'd2) begin
                d = 1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("midRunReached", 64'(d), 64'sd1);
        #1 rst_n = 1'b0;
        #1 checkResetValues("midReset");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, d);
        checkOutput("afterResetY", yOut, 64'sd6144);

        for (int run = 0; run < 24; run++) begin
            uk = randVal();
            foreach (prods[i]) prods[i] = randVal();
            applyStimulus((run % 3 == 0) ? $urandom_range(2, TAPS + 2) : 0, d);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
